// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 front end.
// Holds block geometry, the padding marker, the padder state encoding,
// the SHA-256 initial hash value used by the compression core, and
// small helpers for the byte-count handling of the final message word.
package sha_pkg;

  localparam int         BLOCK_WORDS = 16;
  localparam logic [4:0] LEN_SLOT    = 5'd14;
  localparam logic [4:0] BLOCK_END   = 5'd16;
  localparam logic [7:0] PAD_MARKER  = 8'h80;

  // Padder control states.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_PAD  = 2'd1,
    ST_LEN  = 2'd2,
    ST_EMIT = 2'd3
  } pad_state_e;

  // SHA-256 initial hash value H0..H7, H0 in the top 32 bits.
  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Byte counts above four are treated as a full word.
  function automatic logic [2:0] clamp_bytes(input logic [2:0] n);
    logic [2:0] r;
    if (n > 3'd4) begin
      r = 3'd4;
    end else begin
      r = n;
    end
    return r;
  endfunction

  // A word holding only the padding marker in its first byte.
  function automatic logic [31:0] marker_word();
    return {PAD_MARKER, 24'h000000};
  endfunction

endpackage

// File: rtl/sha_pad_lastword.sv
// Final-word formatter for the message padder.
// Keeps the first nbytes bytes of data (big-endian, first byte in
// data[31:24]), writes the padding marker in the byte right after them
// and clears the rest. With nbytes >= 4 the word passes unchanged.
// Ports:
//   data   - raw final message word
//   nbytes - number of valid bytes, 0..4
//   word   - masked word with the marker inserted
module sha_pad_lastword
  import sha_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] word
);

  // Per-byte select: keep data, insert marker, or zero.
  always_comb begin
    word = 32'h00000000;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes) begin
        word[31-8*b -: 8] = data[31-8*b -: 8];
      end else if (3'(b) == nbytes) begin
        word[31-8*b -: 8] = PAD_MARKER;
      end else begin
        word[31-8*b -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder.
// Collects a byte-packed 32-bit word stream, appends the 0x80 marker,
// zero fill and the big-endian bit length, and hands complete 512-bit
// blocks to the compression core (word 0 in M[511:480]).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_data/valid   - message word stream, first byte in in_data[31:24]
//   in_ready        - a word is accepted when in_valid && in_ready
//   in_last/bytes   - final word marker and its valid byte count (0..4)
//   M, M_valid      - assembled block and its one-cycle load pulse
//   M_first/M_last  - block is first / final of its message
//   core_ready      - compression core can take a block
//   busy            - a message is in flight
module sha_msg_padder
  import sha_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic [511:0] M,
  output logic         M_valid,
  output logic         M_first,
  output logic         M_last,
  input  logic         core_ready,
  output logic         busy
);

  pad_state_e       state_r, state_n;
  pad_state_e       ret_r, ret_n;       // state to resume after a non-final emit
  logic [4:0]       idx_r, idx_n;       // next slot to write, 0..16
  logic [LEN_W-1:0] len_r, len_n;
  logic             first_r, first_n;
  logic             last_r, last_n;
  logic             pend_r, pend_n;     // marker still owed after a full last word
  logic             busy_r, busy_n;
  logic             in_ready_r;
  logic [31:0]      blk_r [BLOCK_WORDS];
  logic [511:0]     M_r;
  logic             M_valid_r, M_first_r, M_last_r;

  logic             accept_s;
  logic             wr_en_s;
  logic [31:0]      wr_data_s;
  logic             emit_s;
  logic [31:0]      lastword_s;
  logic [2:0]       bytes_eff_s;
  logic [63:0]      len64_s;
  logic [4:0]       idx_inc_s;

  sha_pad_lastword u_lastword (
    .data   (in_data),
    .nbytes (in_bytes),
    .word   (lastword_s)
  );

  assign accept_s    = (state_r == ST_FILL) && in_ready_r && in_valid;
  assign bytes_eff_s = clamp_bytes(in_bytes);
  assign len64_s     = 64'(len_r);
  assign idx_inc_s   = idx_r + 5'd1;

  // Next-state, slot write and bookkeeping decode.
  always_comb begin
    state_n   = state_r;
    ret_n     = ret_r;
    idx_n     = idx_r;
    len_n     = len_r;
    first_n   = first_r;
    last_n    = last_r;
    pend_n    = pend_r;
    busy_n    = busy_r;
    wr_en_s   = 1'b0;
    wr_data_s = 32'h00000000;
    emit_s    = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (accept_s) begin
          wr_en_s = 1'b1;
          idx_n   = idx_inc_s;
          busy_n  = 1'b1;
          if (in_last) begin
            wr_data_s = lastword_s;
            len_n     = len_r + LEN_W'({bytes_eff_s, 3'b000});
            pend_n    = (bytes_eff_s == 3'd4);
            last_n    = 1'b0;
            if (idx_inc_s == BLOCK_END) begin
              state_n = ST_EMIT;
              ret_n   = ST_PAD;
            end else begin
              state_n = ST_PAD;
            end
          end else begin
            wr_data_s = in_data;
            len_n     = len_r + LEN_W'(6'd32);
            if (idx_inc_s == BLOCK_END) begin
              state_n = ST_EMIT;
              ret_n   = ST_FILL;
              last_n  = 1'b0;
            end else begin
              state_n = ST_FILL;
            end
          end
        end else begin
          state_n = ST_FILL;
        end
      end
      ST_PAD: begin
        // Marker already placed at or before slot 13: length fits here.
        if ((idx_r == LEN_SLOT) && !pend_r) begin
          state_n = ST_LEN;
        end else begin
          wr_en_s   = 1'b1;
          wr_data_s = pend_r ? marker_word() : 32'h00000000;
          pend_n    = 1'b0;
          idx_n     = idx_inc_s;
          if (idx_inc_s == BLOCK_END) begin
            state_n = ST_EMIT;
            ret_n   = ST_PAD;
            last_n  = 1'b0;
          end else if (idx_inc_s == LEN_SLOT) begin
            state_n = ST_LEN;
          end else begin
            state_n = ST_PAD;
          end
        end
      end
      ST_LEN: begin
        wr_en_s = 1'b1;
        idx_n   = idx_inc_s;
        if (idx_r == LEN_SLOT) begin
          wr_data_s = len64_s[63:32];
          state_n   = ST_LEN;
        end else begin
          wr_data_s = len64_s[31:0];
          state_n   = ST_EMIT;
          last_n    = 1'b1;
        end
      end
      ST_EMIT: begin
        if (core_ready) begin
          emit_s = 1'b1;
          idx_n  = 5'd0;
          if (last_r) begin
            state_n = ST_FILL;
            len_n   = '0;
            first_n = 1'b1;
            last_n  = 1'b0;
            busy_n  = 1'b0;
          end else begin
            state_n = ret_r;
            first_n = 1'b0;
          end
        end else begin
          state_n = ST_EMIT;
        end
      end
      default: begin
        state_n = ST_FILL;
      end
    endcase
  end

  // Control state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FILL;
      ret_r      <= ST_FILL;
      idx_r      <= 5'd0;
      len_r      <= '0;
      first_r    <= 1'b1;
      last_r     <= 1'b0;
      pend_r     <= 1'b0;
      busy_r     <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      ret_r      <= ret_n;
      idx_r      <= idx_n;
      len_r      <= len_n;
      first_r    <= first_n;
      last_r     <= last_n;
      pend_r     <= pend_n;
      busy_r     <= busy_n;
      in_ready_r <= (state_n == ST_FILL);
    end
  end

  // Block buffer: one slot written per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        blk_r[i] <= 32'h00000000;
      end
    end else if (wr_en_s) begin
      blk_r[idx_r[3:0]] <= wr_data_s;
    end else begin
      blk_r[idx_r[3:0]] <= blk_r[idx_r[3:0]];
    end
  end

  // Output block register, loaded once per emitted block and held.
  always_ff @(posedge clk) begin
    if (rst) begin
      M_r       <= 512'h0;
      M_valid_r <= 1'b0;
      M_first_r <= 1'b0;
      M_last_r  <= 1'b0;
    end else if (emit_s) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        M_r[511-32*i -: 32] <= blk_r[i];
      end
      M_valid_r <= 1'b1;
      M_first_r <= first_r;
      M_last_r  <= last_r;
    end else begin
      M_valid_r <= 1'b0;
    end
  end

  assign M        = M_r;
  assign M_valid  = M_valid_r;
  assign M_first  = M_first_r;
  assign M_last   = M_last_r;
  assign busy     = busy_r;
  assign in_ready = in_ready_r;

endmodule

// File: tb/tb_sha_msg_padder.sv
module tb_sha_msg_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic [511:0] M;
  logic         M_valid;
  logic         M_first;
  logic         M_last;
  logic         core_ready;
  logic         busy;

  always #5 clk = ~clk;

  sha_msg_padder #(.LEN_W(64)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_bytes(in_bytes),
    .M(M), .M_valid(M_valid), .M_first(M_first), .M_last(M_last),
    .core_ready(core_ready), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cr_rand  = 1'b0;

  logic [7:0]   msg_q[$];
  logic [511:0] exp_m[$];
  logic [511:0] cap_m[$];
  bit           cap_f[$];
  bit           cap_l[$];
  int           pulse_cnt = 0;

  typedef struct {
    int nbytes;
    int exp_blocks;
    int gap;
  } vec_t;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output monitor: every load pulse records one block.
  always @(negedge clk) begin
    if (M_valid === 1'b1) begin
      cap_m.push_back(M);
      cap_f.push_back(M_first);
      cap_l.push_back(M_last);
      pulse_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (cr_rand) core_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference: byte-level padding per the SHA-256 rules.
  task automatic model_blocks(input int n);
    logic [7:0]   p[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    p = msg_q;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bitlen = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
    exp_m.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b + j];
      exp_m.push_back(blk);
    end
  endtask

  task automatic send_msg(input int n, input int gap_max, input int max_words);
    int nwords;
    int t;
    int bi;
    logic [31:0] w32;
    nwords = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nwords && w < max_words; w++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
      end
      for (int b = 0; b < 4; b++) begin
        bi = 4 * w + b;
        w32[31-8*b -: 8] = (bi < n) ? msg_q[bi] : 8'($urandom_range(0, 255));
      end
      in_data  = w32;
      in_valid = 1'b1;
      in_last  = (w == nwords - 1);
      in_bytes = (w == nwords - 1) ? 3'(n - 4 * w) : 3'($urandom_range(0, 7));
      t = 0;
      while (in_ready !== 1'b1 && t < 500) begin
        tick();
        t++;
      end
      if (t >= 500) chk("accept_timeout", 1'b1, 1'b0);
      tick();
      if (w == 0) chk("busy_after_first_word", busy, 1'b1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_blocks(input int k);
    int t;
    t = 0;
    while (cap_m.size() < k && t < 3000) begin
      tick();
      t++;
    end
    chk("block_count", cap_m.size(), k);
  endtask

  task automatic compare_blocks(input string name);
    for (int i = 0; i < exp_m.size() && i < cap_m.size(); i++) begin
      chk($sformatf("%s_M%0d", name, i), cap_m[i], exp_m[i]);
      chk($sformatf("%s_first%0d", name, i), cap_f[i], (i == 0));
      chk($sformatf("%s_last%0d", name, i), cap_l[i], (i == exp_m.size() - 1));
    end
  endtask

  task automatic run_msg(input string name, input int n, input int gap, input bit preset);
    if (!preset) begin
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    end
    model_blocks(n);
    cap_m.delete(); cap_f.delete(); cap_l.delete();
    send_msg(n, gap, 1000);
    wait_blocks(exp_m.size());
    compare_blocks(name);
    chk({name, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    int   viol;
    int   p0;

    tbl[0]  = '{0, 1, 0};   tbl[1]  = '{1, 1, 1};   tbl[2]  = '{3, 1, 0};
    tbl[3]  = '{4, 1, 2};   tbl[4]  = '{55, 1, 0};  tbl[5]  = '{56, 2, 1};
    tbl[6]  = '{57, 2, 0};  tbl[7]  = '{60, 2, 0};  tbl[8]  = '{63, 2, 2};
    tbl[9]  = '{64, 2, 0};  tbl[10] = '{65, 2, 1};  tbl[11] = '{119, 2, 0};
    tbl[12] = '{120, 3, 0}; tbl[13] = '{128, 3, 1};

    rst = 1'b1; in_data = 32'h0; in_valid = 1'b0; in_last = 1'b0;
    in_bytes = 3'd0; core_ready = 1'b0;
    repeat (3) tick();
    chk("rst_M", M, 512'h0);
    chk("rst_outs", {M_valid, M_first, M_last, busy, in_ready}, 5'b0);
    rst = 1'b0;
    chk("rst_release_in_ready", in_ready, 1'b0);
    repeat (2) tick();
    chk("fill_ready", in_ready, 1'b1);
    core_ready = 1'b1;

    // Scenario 1: "abc"
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", 3, 0, 1'b1);
    chk("abc_literal", cap_m[0], {32'h61626380, 416'h0, 32'h0, 32'h00000018});

    // Scenario 2: empty message
    msg_q.delete();
    run_msg("empty", 0, 0, 1'b1);
    chk("empty_literal", cap_m[0], {32'h80000000, 480'h0});

    // Scenario 3: 56 bytes
    run_msg("b56", 56, 0, 1'b0);
    chk("b56_blk2_literal", cap_m[1], {480'h0, 32'h000001C0});
    chk("b56_blk1_marker", cap_m[0][63:32], 32'h80000000);

    // Scenario 4: 64 bytes
    run_msg("b64", 64, 0, 1'b0);
    chk("b64_blk2_literal", cap_m[1], {32'h80000000, 416'h0, 32'h0, 32'h00000200});

    // Table-driven length boundaries
    for (int i = 0; i < 14; i++) begin
      run_msg($sformatf("tbl%0d", tbl[i].nbytes), tbl[i].nbytes, tbl[i].gap, 1'b0);
      chk($sformatf("tbl%0d_nblocks", tbl[i].nbytes), cap_m.size(), tbl[i].exp_blocks);
    end

    // Randomized messages with random core back-pressure
    cr_rand = 1'b1;
    for (int r = 0; r < 25; r++) begin
      run_msg($sformatf("rnd%0d", r), $urandom_range(0, 150), $urandom_range(0, 3), 1'b0);
    end
    cr_rand = 1'b0;
    core_ready = 1'b1;
    repeat (4) tick();

    // Scenario 5: core stalls in EMIT
    core_ready = 1'b0;
    msg_q = '{8'h61, 8'h62, 8'h63};
    model_blocks(3);
    cap_m.delete(); cap_f.delete(); cap_l.delete();
    p0 = pulse_cnt;
    send_msg(3, 0, 1000);
    viol = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (M_valid !== 1'b0 || in_ready !== 1'b0) viol++;
    end
    chk("stall_quiet", viol, 0);
    core_ready = 1'b1;
    tick();
    chk("stall_release_pulse", M_valid, 1'b1);
    repeat (8) tick();
    chk("stall_single_pulse", pulse_cnt - p0, 1);
    compare_blocks("stall");

    // Scenario 6: reset mid-message, then "abc"
    msg_q.delete();
    for (int i = 0; i < 40; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    cap_m.delete(); cap_f.delete(); cap_l.delete();
    send_msg(40, 0, 5);
    rst = 1'b1;
    repeat (2) tick();
    chk("midrst_outs", {M_valid, busy, in_ready}, 3'b0);
    rst = 1'b0;
    repeat (2) tick();
    chk("midrst_no_block", cap_m.size(), 0);
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg("abc_after_rst", 3, 0, 1'b1);
    chk("abc_after_rst_literal", cap_m[0], {32'h61626380, 416'h0, 32'h0, 32'h00000018});
    chk("abc_after_rst_first", cap_f[0], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
